// File: rtl/rally_pkg.sv
// Shared types and constants for the table-tennis rally sequencer.
// Positions run from the player A end (POS_A) to the player B end (POS_B).
package rally_pkg;

    localparam int POS_A = 0;
    localparam int POS_B = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_TO_B,
        S_TO_A,
        S_POINT,
        S_OVER
    } rally_st_t;

    typedef enum logic {
        PL_A,
        PL_B
    } player_t;

endpackage

// File: rtl/rise_det.sv
// Single-register rising-edge detector for a debounced button level.
// A held button yields exactly one pulse.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_p0 <= 1'b0;
        end else begin
            din_p0 <= din;
        end
    end

    assign rise = din & ~din_p0;

endmodule

// File: rtl/rally_ctrl.sv
// Table-tennis game sequencer: ball movement, serves, returns, misses,
// scoring and winner detection. All outputs are registered.
module rally_ctrl
    import rally_pkg::*;
#(
    parameter int NPOS       = POS_B + 1,
    parameter int SCORE_W    = 4,
    parameter int WIN_SCORE  = 11,
    parameter int HOLD_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               hit_a,
    input  logic               hit_b,
    output logic               on,
    output logic [2:0]         state,
    output logic               lost_a,
    output logic               lost_b,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               game_over
);

    localparam logic [2:0]         POS_FIRST = 3'(POS_A);
    localparam logic [2:0]         POS_LAST  = 3'(NPOS - 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         HOLD_LAST = 8'(HOLD_TICKS - 1);

    rally_st_t          fsm_q, fsm_n;
    player_t            server_q, server_n;
    player_t            scorer_q, scorer_n;
    logic [2:0]         pos_q, pos_n;
    logic [SCORE_W-1:0] score_a_q, score_a_n;
    logic [SCORE_W-1:0] score_b_q, score_b_n;
    logic               lost_a_q, lost_a_n;
    logic               lost_b_q, lost_b_n;
    logic [7:0]         hold_q, hold_n;
    logic               on_q, on_n;
    logic               over_q, over_n;
    logic               rise_a, rise_b;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v >= WIN) ? WIN : v + 1'b1;
    endfunction

    rise_det u_rise_a (.clk(clk), .rst(rst), .din(hit_a), .rise(rise_a));
    rise_det u_rise_b (.clk(clk), .rst(rst), .din(hit_b), .rise(rise_b));

    always_comb begin
        fsm_n     = fsm_q;
        server_n  = server_q;
        scorer_n  = scorer_q;
        pos_n     = pos_q;
        score_a_n = score_a_q;
        score_b_n = score_b_q;
        lost_a_n  = lost_a_q;
        lost_b_n  = lost_b_q;
        hold_n    = hold_q;

        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    fsm_n     = S_SERVE;
                    server_n  = PL_A;
                    pos_n     = POS_FIRST;
                    score_a_n = '0;
                    score_b_n = '0;
                    lost_a_n  = 1'b0;
                    lost_b_n  = 1'b0;
                end
            end
            S_SERVE: begin
                pos_n = (server_q == PL_A) ? POS_FIRST : POS_LAST;
                if (server_q == PL_A && rise_a) begin
                    fsm_n = S_TO_B;
                end else if (server_q == PL_B && rise_b) begin
                    fsm_n = S_TO_A;
                end
            end
            S_TO_B: begin
                // At the B end the window is open; a return beats a same-cycle tick.
                if (pos_q == POS_LAST) begin
                    if (rise_b) begin
                        fsm_n = S_TO_A;
                    end else if (tick) begin
                        fsm_n     = S_POINT;
                        score_a_n = sat_inc(score_a_q);
                        lost_b_n  = 1'b1;
                        scorer_n  = PL_A;
                        hold_n    = '0;
                    end
                end else if (tick) begin
                    pos_n = pos_q + 3'd1;
                end
            end
            S_TO_A: begin
                if (pos_q == POS_FIRST) begin
                    if (rise_a) begin
                        fsm_n = S_TO_B;
                    end else if (tick) begin
                        fsm_n     = S_POINT;
                        score_b_n = sat_inc(score_b_q);
                        lost_a_n  = 1'b1;
                        scorer_n  = PL_B;
                        hold_n    = '0;
                    end
                end else if (tick) begin
                    pos_n = pos_q - 3'd1;
                end
            end
            S_POINT: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        lost_a_n = 1'b0;
                        lost_b_n = 1'b0;
                        if (scorer_q == PL_A) begin
                            if (score_a_q == WIN) begin
                                fsm_n    = S_OVER;
                                lost_b_n = 1'b1;
                            end else begin
                                fsm_n    = S_SERVE;
                                server_n = PL_B;
                                pos_n    = POS_LAST;
                            end
                        end else begin
                            if (score_b_q == WIN) begin
                                fsm_n    = S_OVER;
                                lost_a_n = 1'b1;
                            end else begin
                                fsm_n    = S_SERVE;
                                server_n = PL_A;
                                pos_n    = POS_FIRST;
                            end
                        end
                    end else begin
                        hold_n = hold_q + 8'd1;
                    end
                end
            end
            S_OVER: begin
            end
            default: fsm_n = S_IDLE;
        endcase

        // Dropping the enable switch abandons the game but keeps the scores visible.
        if (fsm_q != S_IDLE && !start) begin
            fsm_n    = S_IDLE;
            lost_a_n = 1'b0;
            lost_b_n = 1'b0;
        end

        on_n   = (fsm_n != S_IDLE);
        over_n = (fsm_n == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            server_q  <= PL_A;
            scorer_q  <= PL_A;
            pos_q     <= POS_FIRST;
            score_a_q <= '0;
            score_b_q <= '0;
            lost_a_q  <= 1'b0;
            lost_b_q  <= 1'b0;
            hold_q    <= '0;
            on_q      <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_n;
            server_q  <= server_n;
            scorer_q  <= scorer_n;
            pos_q     <= pos_n;
            score_a_q <= score_a_n;
            score_b_q <= score_b_n;
            lost_a_q  <= lost_a_n;
            lost_b_q  <= lost_b_n;
            hold_q    <= hold_n;
            on_q      <= on_n;
            over_q    <= over_n;
        end
    end

    assign on        = on_q;
    assign state     = pos_q;
    assign lost_a    = lost_a_q;
    assign lost_b    = lost_b_q;
    assign score_a   = score_a_q;
    assign score_b   = score_b_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Directed bench for rally_ctrl: serves, returns, misses, the hit/tick race,
// ignored hits, a full game to 11, restart and mid-rally reset.
module tb_rally_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, start, hit_a, hit_b;
    logic       on, lost_a, lost_b, game_over;
    logic [2:0] state;
    logic [3:0] score_a, score_b;

    int n_chk  = 0;
    int n_fail = 0;

    rally_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .hit_a(hit_a), .hit_b(hit_b), .on(on), .state(state),
        .lost_a(lost_a), .lost_b(lost_b), .score_a(score_a),
        .score_b(score_b), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic press(input bit is_b);
        if (is_b) hit_b = 1'b1; else hit_a = 1'b1;
        step(1);
        hit_a = 1'b0;
        hit_b = 1'b0;
        step(1);
    endtask

    // B serves from 5, A returns at 0, B misses at 5, then the hold elapses.
    task automatic a_scores(input int exp_score);
        press(1'b1);
        ticks(5);
        press(1'b0);
        ticks(5);
        do_tick();
        chk("pt_score_a", 32'(score_a), 32'(exp_score));
        chk("pt_lost_b", 32'(lost_b), 32'd1);
        ticks(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; hit_a = 1'b0; hit_b = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_on", 32'(on), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lost", 32'({lost_a, lost_b}), 32'd0);
        chk("rst_scores", 32'({score_a, score_b}), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);

        start = 1'b1;
        step(1);
        chk("serve_on", 32'(on), 32'd1);
        chk("serve_pos", 32'(state), 32'd0);
        do_tick();
        chk("serve_tick_hold", 32'(state), 32'd0);
        press(1'b0);
        chk("served_pos", 32'(state), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            do_tick();
            chk("to_b_pos", 32'(state), 32'(i));
        end
        chk("to_b_nolost", 32'({lost_a, lost_b}), 32'd0);

        // B returns inside the window
        press(1'b1);
        chk("ret_b_hold", 32'(state), 32'd5);
        do_tick();
        chk("ret_b_pos", 32'(state), 32'd4);
        chk("ret_b_scores", 32'({score_a, score_b}), 32'd0);
        ticks(4);
        chk("to_a_end", 32'(state), 32'd0);
        press(1'b0);
        ticks(5);
        chk("to_b_end", 32'(state), 32'd5);

        // B misses
        do_tick();
        chk("miss_score_a", 32'(score_a), 32'd1);
        chk("miss_lost_b", 32'(lost_b), 32'd1);
        chk("miss_pos", 32'(state), 32'd5);
        do_tick();
        chk("hold1_lost_b", 32'(lost_b), 32'd1);
        do_tick();
        chk("hold2_lost_b", 32'(lost_b), 32'd0);
        chk("bserve_pos", 32'(state), 32'd5);

        // non-server hit ignored, then B serves
        press(1'b0);
        do_tick();
        chk("nonserver_ign", 32'(state), 32'd5);
        press(1'b1);
        ticks(5);
        chk("b_serve_to_a", 32'(state), 32'd0);
        press(1'b0);
        ticks(5);

        // hit_b together with the closing tick counts as a return
        tick = 1'b1; hit_b = 1'b1;
        step(1);
        tick = 1'b0; hit_b = 1'b0;
        step(1);
        chk("race_score_a", 32'(score_a), 32'd1);
        chk("race_lost_b", 32'(lost_b), 32'd0);
        chk("race_pos", 32'(state), 32'd5);
        do_tick();
        chk("race_next", 32'(state), 32'd4);
        ticks(4);
        press(1'b0);
        ticks(3);
        chk("early_at3", 32'(state), 32'd3);
        press(1'b1);
        press(1'b0);
        do_tick();
        chk("early_ign_dir", 32'(state), 32'd4);
        do_tick();
        do_tick();
        chk("early_miss_a", 32'(score_a), 32'd2);
        chk("early_miss_lost", 32'(lost_b), 32'd1);
        ticks(2);

        for (int s = 3; s <= 11; s++) a_scores(s);
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_lost_b", 32'(lost_b), 32'd1);
        chk("over_on", 32'(on), 32'd1);
        press(1'b1);
        ticks(3);
        chk("over_frozen", 32'(score_a), 32'd11);
        chk("over_score_b", 32'(score_b), 32'd0);

        start = 1'b0;
        step(1);
        chk("stop_on", 32'(on), 32'd0);
        chk("stop_over", 32'(game_over), 32'd0);
        chk("stop_lost", 32'(lost_b), 32'd0);
        chk("stop_keep", 32'(score_a), 32'd11);
        start = 1'b1;
        step(1);
        chk("restart_scores", 32'({score_a, score_b}), 32'd0);
        chk("restart_on", 32'(on), 32'd1);

        // A misses: score_b
        press(1'b0);
        ticks(5);
        press(1'b1);
        ticks(5);
        do_tick();
        chk("amiss_score_b", 32'(score_b), 32'd1);
        chk("amiss_lost_a", 32'(lost_a), 32'd1);
        ticks(2);
        chk("aserve_pos", 32'(state), 32'd0);
        chk("aserve_lost_a", 32'(lost_a), 32'd0);

        // reset mid-rally
        press(1'b0);
        ticks(2);
        rst = 1'b1; tick = 1'b1; hit_b = 1'b1;
        step(1);
        rst = 1'b0; tick = 1'b0; hit_b = 1'b0;
        chk("mrst_pos", 32'(state), 32'd0);
        chk("mrst_on", 32'(on), 32'd0);
        chk("mrst_score_b", 32'(score_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rally_ctrl.md
Name: rally_ctrl

Overview:
- Game sequencer for the table-tennis simulation: it moves the ball position, handles player serves and hits, detects missed returns, keeps score and decides the winner.
- Drives the LED display block's inputs (on, 3-bit position, lost flags), so the display only renders.
- Runs on the system clock; the 1 Hz ball step arrives as a one-cycle tick enable.

Parameters:
- NPOS, 6, number of ball positions; position 0 = player A end, NPOS-1 = player B end.
- SCORE_W, 4, score counter width.
- WIN_SCORE, 11, points needed to win the game; must be < 2^SCORE_W.
- HOLD_TICKS, 2, ticks the point-lost indication is held before the next serve.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse, 1 Hz, ball step enable.
- start  in  1  game-enable switch (level).
- hit_a  in  1  player A button, debounced level.
- hit_b  in  1  player B button, debounced level.
- on  out  1  game active (display enable).
- state  out  3  ball position 0..NPOS-1.
- lost_a  out  1  A lost the current point / the game.
- lost_b  out  1  B lost the current point / the game.
- score_a  out  SCORE_W  A points.
- score_b  out  SCORE_W  B points.
- game_over  out  1  a player reached WIN_SCORE.

Behaviour:
- All outputs registered. Reset values: on=0, state=0, lost_a=lost_b=0, scores=0, game_over=0, FSM=IDLE, server=A.
- Hits are rising edges of hit_a/hit_b, detected on clk; a held button produces one hit.
- FSM states: IDLE, SERVE, TO_B, TO_A, POINT, OVER.
- IDLE: on=0. When start=1, clear both scores, set server=A and go to SERVE next cycle.
- SERVE: on=1; state=0 if server=A, else NPOS-1.
  - A hit by the server goes to TO_B (server A) or TO_A (server B). The position does not change until the next tick.
  - Hits by the non-server are ignored.
- TO_B: each tick does state+1, saturating at NPOS-1.
  - Hit window is open while state==NPOS-1, from the cycle after the arrival tick.
  - hit_b in the window goes to TO_A with state held; the next tick does state-1.
  - A tick with the window open and no hit_b in that cycle: score_a+1, lost_b=1, go to POINT.
  - hit_b in the same cycle as the closing tick counts as a return; the hit has priority over the miss.
  - hit_b outside the window and any hit_a are ignored.
- TO_A: mirror of TO_B (decrement, window at state==0, miss gives score_b+1 and lost_a=1).
- POINT:
  - Hold state and the lost flag for HOLD_TICKS ticks.
  - Then clear the lost flag. If the scorer's score == WIN_SCORE, go to OVER. Otherwise go to SERVE with server = loser of the point.
- OVER: game_over=1; the loser's lost flag is asserted and held; scores frozen.
- start=0 in any state except IDLE goes to IDLE next cycle. This clears on, lost flags and game_over; scores are retained until the next start.
- Scores saturate at WIN_SCORE and never wrap.
- A tick and a hit in the same cycle outside a window: the tick moves the ball and the hit is ignored.
- rst mid-rally returns to reset values next cycle regardless of tick/hit.

Decomposition:
- Package rally_pkg holds:
  - the FSM state enum;
  - position constants POS_A=0 and POS_B=NPOS-1;
  - the player enum (A/B) used for server and scorer.
- One sub-module, rise_det (single-register rising-edge detector with synchronous reset). It is instantiated twice, for hit_a and hit_b.

Test Plan:
- rst, start=1, hit_a pulse, then 5 ticks -> state 0,1,2,3,4,5; on=1; no lost flag.
- Ball at 5, hit_b pulse between ticks -> next tick state=4, direction toward A; scores unchanged.
- Ball at 5, tick with no hit_b -> score_a=1, lost_b=1 for 2 ticks, then SERVE with server=B, state=5, lost_b=0.
- hit_b asserted in the same cycle as the closing tick at state 5 -> counted as a return; next tick state=4; no point.
- Early hit_b at state=3 and hit_a while the ball travels toward B -> ignored. The ball reaches 5 and a miss scores A.
- Play to score_a=11 -> game_over=1, lost_b held; then start=0 -> on=0, game_over=0; start=1 again -> scores reset to 0.
